reg10_serial_tx: RTL

Parallel-in, serial-out transmitter that reads a 10-bit word from the datapath's register bank and shifts it out one bit per transfer over a valid/ready serial link. It is the read-side counterpart to the 10-bit S2-cell storage register: a word held in that register is loaded here and drained bit by bit toward the downstream serial consumer. Internally it has a two-state controller, a bit counter and a shift register, and all outputs are registered.

---
 rtl/reg10_serial_tx.sv | 104 ++++++++++
 1 files changed

// File: rtl/reg10_serial_tx.sv
// Parallel-in, serial-out transmitter: loads a WIDTH-bit word and drains it one
// bit per valid/ready transfer, pulsing done after the final bit.
module reg10_serial_tx #(
  parameter int WIDTH     = 10,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] shreg_r;

  // The bit at the output end of a word, for the configured bit order.
  function automatic logic out_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  // Move the word one position toward the output end.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
  endfunction

  // Controller, bit counter, shift register and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      shreg_r   <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          // in_ready is held low out of reset until the first edge.
          if (in_ready && in_valid) begin
            state_r   <= SHIFT;
            shreg_r   <= in_data;
            cnt_r     <= '0;
            ser_out   <= out_bit(in_data);
            ser_valid <= 1'b1;
            ser_last  <= (LAST_IDX == '0);
            in_ready  <= 1'b0;
          end else begin
            in_ready  <= 1'b1;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            ser_out   <= 1'b0;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            if (cnt_r == LAST_IDX) begin
              state_r   <= IDLE;
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
              ser_out   <= 1'b0;
              done      <= 1'b1;
              in_ready  <= 1'b1;
            end else begin
              shreg_r  <= shift_word(shreg_r);
              ser_out  <= out_bit(shift_word(shreg_r));
              cnt_r    <= cnt_r + CW'(1);
              ser_last <= ((cnt_r + CW'(1)) == LAST_IDX);
            end
          end else begin
            state_r <= SHIFT;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          shreg_r   <= '0;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
